// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the multi-cycle CPU: opcode values, instruction
//   field positions, FSM state encoding and ALU operation select.
//   No ports (package).
package cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   // Instruction word: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm
   localparam int unsigned OPC_LSB  = 24;
   localparam int unsigned DST_LSB  = 16;
   localparam int unsigned SRC1_LSB = 8;
   localparam int unsigned SRC2_LSB = 0;
   localparam int unsigned FIELD_W  = 8;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_PASS
   } alu_op_t;

endpackage

// File: rtl/cpu_alu_w.sv
// cpu_alu_w
//   Combinational ALU of parametrised width: add, sub, and, or, pass-b,
//   with a zero flag on the result (used for beq equality).
// Ports:
//   a, b  in  DATA_W  operands
//   op    in  3       operation select (cpu_pkg::alu_op_t encoding)
//   y     out DATA_W  result, modulo 2^DATA_W
//   zero  out 1       y == 0
module cpu_alu_w
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] y,
   output logic              zero
);

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a + ~b + DATA_W'(1);
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_PASS: y = b;
         default:  y = '0;
      endcase
      zero = (y == '0);
   end

endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle
//   Multi-cycle CPU core: FETCH (req/ack) -> DECODE -> EXECUTE -> WRITEBACK,
//   with a terminal HALT state and illegal-opcode reporting.
//   Optional feature macro: CPU_BRANCH_EN adds j (06) and beq (07);
//   without it those opcodes are illegal and executed as NOP.
// Ports:
//   CLK          in   1   rising-edge clock
//   RESET_N      in   1   asynchronous active-low reset
//   PC           out  32  address of the instruction being fetched/executed
//   INSTR_REQ    out  1   fetch request, held until INSTR_ACK
//   INSTR_ACK    in   1   INSTRUCTION valid this cycle
//   INSTRUCTION  in   32  instruction word
//   HALTED       out  1   HALT has executed (until reset)
//   ILLEGAL      out  1   one-cycle pulse in EXECUTE on an undefined opcode
module cpu_multicycle
   import cpu_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter int          REG_COUNT = 8,
   parameter logic [31:0] PC_RESET  = '0
) (
   input  logic        CLK,
   input  logic        RESET_N,
   output logic [31:0] PC,
   output logic        INSTR_REQ,
   input  logic        INSTR_ACK,
   input  logic [31:0] INSTRUCTION,
   output logic        HALTED,
   output logic        ILLEGAL
);

   localparam int RIDX_W = $clog2(REG_COUNT);

`ifdef CPU_BRANCH_EN
   localparam logic BRANCH_EN = 1'b1;
`else
   localparam logic BRANCH_EN = 1'b0;
`endif

   state_t              state, state_next;
   logic                req_q, req_next;
   logic [31:0]         ir;
   logic [DATA_W-1:0]   regs [REG_COUNT];
   logic [DATA_W-1:0]   opa, opb, result;
   logic                taken;

   logic                ir_load, opnd_load, res_load, wb_en;

   logic [7:0]          opcode;
   logic                dec_legal, dec_writes, dec_jump, dec_beq, dec_halt;
   alu_op_t             dec_alu;

   logic [DATA_W-1:0]   imm_ext, alu_b, alu_y;
   logic                alu_zero;
   logic [31:0]         pc_plus4, br_offset, br_target;
   logic                unused_ir_bits;

   assign opcode    = ir[OPC_LSB +: FIELD_W];
   // imm8 sign-extends when DATA_W > 8 and truncates when DATA_W < 8
   assign imm_ext   = DATA_W'(signed'(ir[SRC2_LSB +: FIELD_W]));
   assign alu_b     = (opcode == OP_LOADI) ? imm_ext : opb;
   assign pc_plus4  = PC + 32'd4;
   assign br_offset = {{22{ir[DST_LSB+7]}}, ir[DST_LSB +: FIELD_W], 2'b00};
   assign br_target = pc_plus4 + br_offset;
   assign unused_ir_bits = ^{ir[SRC1_LSB +: FIELD_W], ir[DST_LSB +: FIELD_W]};

   assign INSTR_REQ = req_q;
   assign HALTED    = (state == S_HALT);

   // Opcode decode
   always_comb begin
      dec_legal  = 1'b0;
      dec_writes = 1'b0;
      dec_jump   = 1'b0;
      dec_beq    = 1'b0;
      dec_halt   = 1'b0;
      dec_alu    = ALU_PASS;
      case (opcode)
         OP_LOADI: begin dec_legal = 1'b1; dec_writes = 1'b1; dec_alu = ALU_PASS; end
         OP_MOV:   begin dec_legal = 1'b1; dec_writes = 1'b1; dec_alu = ALU_PASS; end
         OP_ADD:   begin dec_legal = 1'b1; dec_writes = 1'b1; dec_alu = ALU_ADD;  end
         OP_SUB:   begin dec_legal = 1'b1; dec_writes = 1'b1; dec_alu = ALU_SUB;  end
         OP_AND:   begin dec_legal = 1'b1; dec_writes = 1'b1; dec_alu = ALU_AND;  end
         OP_OR:    begin dec_legal = 1'b1; dec_writes = 1'b1; dec_alu = ALU_OR;   end
         OP_J: begin
            if (BRANCH_EN) begin
               dec_legal = 1'b1;
               dec_jump  = 1'b1;
            end
         end
         OP_BEQ: begin
            if (BRANCH_EN) begin
               dec_legal = 1'b1;
               dec_beq   = 1'b1;
               dec_alu   = ALU_SUB;
            end
         end
         OP_HALT:  begin dec_legal = 1'b1; dec_halt = 1'b1; end
         default:  ;
      endcase
   end

   cpu_alu_w #(.DATA_W(DATA_W)) u_alu (
      .a    (opa),
      .b    (alu_b),
      .op   (dec_alu),
      .y    (alu_y),
      .zero (alu_zero)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_FETCH;
         req_q <= 1'b0;
      end else begin
         state <= state_next;
         req_q <= req_next;
      end
   end

   // Next state and control. REQ is raised again in WRITEBACK so the next
   // FETCH can accept ACK in its first cycle (4-cycle minimum per instruction).
   always_comb begin
      state_next = state;
      req_next   = req_q;
      ILLEGAL    = 1'b0;
      ir_load    = 1'b0;
      opnd_load  = 1'b0;
      res_load   = 1'b0;
      wb_en      = 1'b0;
      case (state)
         S_FETCH: begin
            req_next = 1'b1;
            if (req_q && INSTR_ACK) begin
               ir_load    = 1'b1;
               req_next   = 1'b0;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            opnd_load  = 1'b1;
            state_next = S_EXECUTE;
         end
         S_EXECUTE: begin
            res_load   = 1'b1;
            ILLEGAL    = !dec_legal;
            state_next = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            if (dec_halt) begin
               req_next   = 1'b0;
               state_next = S_HALT;
            end else begin
               wb_en      = 1'b1;
               req_next   = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_HALT: begin
            req_next = 1'b0;
         end
         default: begin
            req_next   = 1'b0;
            state_next = S_FETCH;
         end
      endcase
   end

   // Datapath: IR, operand latches, result, register file, PC
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         PC     <= PC_RESET;
         ir     <= '0;
         opa    <= '0;
         opb    <= '0;
         result <= '0;
         taken  <= 1'b0;
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (ir_load) begin
            ir <= INSTRUCTION;
         end
         if (opnd_load) begin
            opa <= regs[ir[SRC1_LSB +: RIDX_W]];
            opb <= regs[ir[SRC2_LSB +: RIDX_W]];
         end
         if (res_load) begin
            result <= alu_y;
            taken  <= dec_jump | (dec_beq & alu_zero);
         end
         if (wb_en) begin
            if (dec_writes) begin
               regs[ir[DST_LSB +: RIDX_W]] <= result;
            end
            PC <= taken ? br_target : pc_plus4;
         end
      end
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle
//   Directed-vector bench for cpu_multicycle (DATA_W=8, REG_COUNT=8, PC_RESET=0).
//   Expectations for j/beq follow CPU_BRANCH_EN as the DUT is built.
module tb_cpu_multicycle;

   logic        CLK;
   logic        RESET_N;
   logic [31:0] PC;
   logic        INSTR_REQ;
   logic        INSTR_ACK;
   logic [31:0] INSTRUCTION;
   logic        HALTED;
   logic        ILLEGAL;

   logic [31:0] mem [16];
   int          n_checks = 0;
   int          n_errors = 0;

   cpu_multicycle #(.DATA_W(8), .REG_COUNT(8), .PC_RESET(32'h0)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .PC          (PC),
      .INSTR_REQ   (INSTR_REQ),
      .INSTR_ACK   (INSTR_ACK),
      .INSTRUCTION (INSTRUCTION),
      .HALTED      (HALTED),
      .ILLEGAL     (ILLEGAL)
   );

   assign INSTRUCTION = mem[PC[5:2]];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
   endtask

   // Reset with ACK held high (must be ignored), check reset values, release at negedge.
   task automatic do_reset(input string tag);
      RESET_N   = 1'b0;
      INSTR_ACK = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check({tag, "_pc"},  PC, 32'h0);
      check({tag, "_req"}, {31'b0, INSTR_REQ}, 32'h0);
      check({tag, "_hlt"}, {31'b0, HALTED}, 32'h0);
      check({tag, "_ill"}, {31'b0, ILLEGAL}, 32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   task automatic run_until_halt(input string tag, input int max, output int ill);
      int cyc;
      cyc = 0;
      ill = 0;
      while (!HALTED && cyc < max) begin
         tick();
         cyc++;
         if (ILLEGAL) ill++;
      end
      check({tag, "_halt_reached"}, {31'b0, HALTED}, 32'h1);
   endtask

   initial begin
      int ill;
      RESET_N   = 1'b0;
      INSTR_ACK = 1'b0;
      clear_mem();

      // 1: ACK tied high, 4 cycles per instruction
      do_reset("t1_rst");
      tick();
      check("t1_req_c1", {31'b0, INSTR_REQ}, 32'h1);
      check("t1_pc_c1", PC, 32'h0);
      repeat (3) tick();
      check("t1_pc_c4", PC, 32'h0);
      tick();
      check("t1_pc_c5", PC, 32'h4);
      check("t1_req_c5", {31'b0, INSTR_REQ}, 32'h1);
      repeat (3) tick();
      check("t1_pc_c8", PC, 32'h4);
      tick();
      check("t1_pc_c9", PC, 32'h8);

      // 2: arithmetic program
      clear_mem();
      mem[0]  = 32'h00010005; // loadi r1,5
      mem[1]  = 32'h00020003; // loadi r2,3
      mem[2]  = 32'h03030102; // sub r3,r1,r2
      mem[3]  = 32'h02040303; // add r4,r3,r3
      mem[4]  = 32'h03050201; // sub r5,r2,r1
      mem[5]  = 32'h02010101; // add r1,r1,r1
      mem[6]  = 32'h00060080; // loadi r6,0x80
      mem[7]  = 32'h04070102; // and r7,r1,r2
      mem[8]  = 32'h05000102; // or  r0,r1,r2
      mem[9]  = 32'h01020005; // mov r2,r5
      mem[10] = 32'hFF000000; // halt
      do_reset("t2_rst");
      run_until_halt("t2", 100, ill);
      check("t2_r0", {24'b0, dut.regs[0]}, 32'h0B);
      check("t2_r1", {24'b0, dut.regs[1]}, 32'h0A);
      check("t2_r2", {24'b0, dut.regs[2]}, 32'hFE);
      check("t2_r3", {24'b0, dut.regs[3]}, 32'h02);
      check("t2_r4", {24'b0, dut.regs[4]}, 32'h04);
      check("t2_r5", {24'b0, dut.regs[5]}, 32'hFE);
      check("t2_r6", {24'b0, dut.regs[6]}, 32'h80);
      check("t2_r7", {24'b0, dut.regs[7]}, 32'h02);
      check("t2_pc", PC, 32'd40);
      check("t2_ill", ill, 32'd0);

      // 3: ACK withheld for 3 cycles on the second fetch
      clear_mem();
      do_reset("t3_rst");
      repeat (4) tick();
      INSTR_ACK = 1'b0;
      tick();
      check("t3_pc_fetch", PC, 32'h4);
      for (int w = 0; w < 3; w++) begin
         tick();
         check("t3_pc_wait", PC, 32'h4);
         check("t3_req_wait", {31'b0, INSTR_REQ}, 32'h1);
      end
      INSTR_ACK = 1'b1;
      repeat (3) tick();
      check("t3_pc_c11", PC, 32'h4);
      tick();
      check("t3_pc_c12", PC, 32'h8);

      // 4: illegal opcode then halt
      clear_mem();
      mem[0] = 32'h00010007; // loadi r1,7
      mem[1] = 32'h3C010101; // undefined
      mem[2] = 32'hFF000000; // halt
      do_reset("t4_rst");
      run_until_halt("t4", 60, ill);
      check("t4_ill_cycles", ill, 32'd1);
      check("t4_r1", {24'b0, dut.regs[1]}, 32'h07);
      check("t4_pc_halt", PC, 32'h8);
      repeat (5) tick();
      check("t4_pc_frozen", PC, 32'h8);
      check("t4_req_low", {31'b0, INSTR_REQ}, 32'h0);
      check("t4_halted", {31'b0, HALTED}, 32'h1);

      // 5: j / beq
      clear_mem();
      mem[0] = 32'h06010000; // j +1
      mem[1] = 32'h00020011; // loadi r2,0x11
      mem[2] = 32'h07FE0102; // beq r1,r2,-2
      mem[3] = 32'hFF000000; // halt
      do_reset("t5_rst");
      ill = 0;
      for (int c = 1; c <= 17; c++) begin
         tick();
         if (ILLEGAL) ill++;
`ifdef CPU_BRANCH_EN
         if (c == 5)  check("t5_pc_after_j", PC, 32'h8);
         if (c == 9)  check("t5_pc_after_beq_taken", PC, 32'h4);
         if (c == 13) check("t5_pc_after_loadi", PC, 32'h8);
         if (c == 17) check("t5_pc_after_beq_not", PC, 32'hC);
`else
         if (c == 5)  check("t5_pc_after_j", PC, 32'h4);
         if (c == 9)  check("t5_pc_after_loadi", PC, 32'h8);
         if (c == 13) check("t5_pc_after_beq", PC, 32'hC);
         if (c == 17) check("t5_pc_halt", PC, 32'hC);
`endif
      end
`ifdef CPU_BRANCH_EN
      check("t5_ill", ill, 32'd0);
`else
      check("t5_ill", ill, 32'd2);
`endif
      check("t5_r2", {24'b0, dut.regs[2]}, 32'h11);

      // 6: asynchronous reset in EXECUTE
      clear_mem();
      mem[0] = 32'h00010005; // loadi r1,5
      mem[1] = 32'h3C000000; // undefined, so ILLEGAL is high in EXECUTE
      do_reset("t6_rst");
      repeat (7) tick();
      check("t6_pre_r1", {24'b0, dut.regs[1]}, 32'h05);
      check("t6_pre_pc", PC, 32'h4);
      check("t6_pre_ill", {31'b0, ILLEGAL}, 32'h1);
      RESET_N = 1'b0;
      #1;
      check("t6_pc", PC, 32'h0);
      check("t6_req", {31'b0, INSTR_REQ}, 32'h0);
      check("t6_ill", {31'b0, ILLEGAL}, 32'h0);
      check("t6_hlt", {31'b0, HALTED}, 32'h0);
      check("t6_r1", {24'b0, dut.regs[1]}, 32'h0);
      repeat (2) tick();
      check("t6_req_held", {31'b0, INSTR_REQ}, 32'h0);
      check("t6_pc_held", PC, 32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      tick();
      check("t6_req_rel", {31'b0, INSTR_REQ}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
